// File: rtl/cache_tag_store_nway.sv
// N-way set-associative tag store: registered lookup with tag compare, tree-PLRU victim
// selection, fill/invalidate writes and a flush sequencer. Optional macro: TAG_PARITY_EN.
module cache_tag_store_nway #(
    parameter int unsigned AWIDTH = 3,
    parameter int unsigned TWIDTH = 14,
    parameter int unsigned WAYS   = 2,
    localparam int unsigned WW    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              ready,
    input  logic              lookup_req,
    input  logic [AWIDTH-1:0] lookup_index,
    input  logic [TWIDTH-1:0] lookup_tag,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [WW-1:0]     rsp_way,
    output logic [WW-1:0]     rsp_victim,
`ifdef TAG_PARITY_EN
    output logic              rsp_perr,
`endif
    input  logic              fill_req,
    input  logic [AWIDTH-1:0] fill_index,
    input  logic [WW-1:0]     fill_way,
    input  logic [TWIDTH-1:0] fill_tag,
    input  logic              inval_req,
    input  logic [AWIDTH-1:0] inval_index,
    input  logic [WW-1:0]     inval_way
);

    localparam int unsigned DEPTH = 1 << AWIDTH;
    localparam int unsigned PW    = (WAYS > 1) ? WAYS - 1 : 1;
    localparam logic [AWIDTH:0] LastSet = (AWIDTH + 1)'(DEPTH - 1);

    typedef enum logic {StFlush, StRun} state_e;

    state_e              state_q, state_d;
    logic [AWIDTH:0]     flush_cnt_q, flush_cnt_d;
    logic [TWIDTH-1:0]   tag_q   [DEPTH][WAYS];
    logic [WAYS-1:0]     valid_q [DEPTH];
    logic [WAYS-1:0]     valid_d [DEPTH];
    logic [PW-1:0]       plru_q  [DEPTH];
    logic [PW-1:0]       plru_d  [DEPTH];

    logic                rsp_valid_q;
    logic [AWIDTH-1:0]   lk_index_q;
    logic [TWIDTH-1:0]   lk_tag_q;
    logic                hit_q;
    logic [WW-1:0]       way_q, victim_q;

    logic                hit, inv_found, perr;
    logic [WW-1:0]       hit_way, inv_way, victim;
    logic [WAYS-1:0]     par_bad;

    // Tree layout for 4 ways: bit0 = root, bit1 = ways 0/1, bit2 = ways 2/3; 0 selects left.
    function automatic logic [WW-1:0] plru_victim(input logic [PW-1:0] p);
        logic [2:0] t;
        logic [1:0] v;
        t = 3'(p);
        v = 2'b00;
        if (WAYS == 2) v = {1'b0, t[0]};
        else if (WAYS == 4) v = t[0] ? {1'b1, t[2]} : {1'b0, t[1]};
        return WW'(v);
    endfunction

    function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] p, input logic [WW-1:0] w);
        logic [2:0] t;
        logic [1:0] x;
        t = 3'(p);
        x = 2'(w);
        if (WAYS == 2) begin
            t[0] = ~x[0];
        end else if (WAYS == 4) begin
            t[0] = ~x[1];
            if (x[1]) t[2] = ~x[0];
            else      t[1] = ~x[0];
        end
        return PW'(t);
    endfunction

    assign ready = (state_q == StRun);

`ifdef TAG_PARITY_EN
    logic par_q [DEPTH][WAYS];

    always_ff @(posedge clock) begin
        if (fill_req && ready) par_q[fill_index][fill_way] <= ^fill_tag;
    end

    always_comb begin
        par_bad = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            par_bad[w] = par_q[lk_index_q][w] != ^tag_q[lk_index_q][w];
        end
    end
`else
    assign par_bad = '0;
`endif

    // Compare against the array as it stands in the response cycle, so same-cycle writes
    // land afterwards (read-before-write).
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[lk_index_q][w] && !par_bad[w] && tag_q[lk_index_q][w] == lk_tag_q) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[lk_index_q][w]) begin
                inv_found = 1'b1;
                inv_way   = WW'(w);
            end
        end
        victim = inv_found ? inv_way : plru_victim(plru_q[lk_index_q]);
        perr   = |(par_bad & valid_q[lk_index_q]);
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        valid_d     = valid_q;
        plru_d      = plru_q;
        unique case (state_q)
            StFlush: begin
                valid_d[flush_cnt_q[AWIDTH-1:0]] = '0;
                plru_d[flush_cnt_q[AWIDTH-1:0]]  = '0;
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == LastSet) state_d = StRun;
            end
            StRun: begin
                if (rsp_valid_q && hit) begin
                    plru_d[lk_index_q] = plru_touch(plru_q[lk_index_q], hit_way);
                end
                if (inval_req) valid_d[inval_index][inval_way] = 1'b0;
                // Applied last so a fill overrides both invalidate and the hit update.
                if (fill_req) begin
                    valid_d[fill_index][fill_way] = 1'b1;
                    plru_d[fill_index] = plru_touch(plru_q[fill_index], fill_way);
                end
            end
            default: state_d = StFlush;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StFlush;
            flush_cnt_q <= '0;
            rsp_valid_q <= 1'b0;
            lk_index_q  <= '0;
            lk_tag_q    <= '0;
            hit_q       <= 1'b0;
            way_q       <= '0;
            victim_q    <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            rsp_valid_q <= lookup_req && ready;
            if (lookup_req && ready) begin
                lk_index_q <= lookup_index;
                lk_tag_q   <= lookup_tag;
            end
            if (rsp_valid_q) begin
                hit_q    <= hit;
                way_q    <= hit_way;
                victim_q <= victim;
            end
        end
    end

    // Valid/PLRU need no reset of their own: the flush sequencer clears them.
    always_ff @(posedge clock) begin
        valid_q <= valid_d;
        plru_q  <= plru_d;
        if (fill_req && ready) tag_q[fill_index][fill_way] <= fill_tag;
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_hit    = rsp_valid_q ? hit     : hit_q;
    assign rsp_way    = rsp_valid_q ? hit_way : way_q;
    assign rsp_victim = rsp_valid_q ? victim  : victim_q;
`ifdef TAG_PARITY_EN
    assign rsp_perr   = rsp_valid_q & perr;
`endif

endmodule

// File: tb/tb_cache_tag_store_nway.sv
// Bench for cache_tag_store_nway: 2-way instance checked every cycle against an LRU-order
// model under random traffic, plus a 4-way instance with hand-computed PLRU expectations.
module tb_cache_tag_store_nway;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    bit          chk_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    // 2-way default instance
    logic        ready, lookup_req, rsp_valid, rsp_hit;
    logic [2:0]  lookup_index, fill_index, inval_index;
    logic [13:0] lookup_tag, fill_tag;
    logic [0:0]  rsp_way, rsp_victim, fill_way, inval_way;
    logic        fill_req, inval_req;
    // 4-way, 4-set instance
    logic        q_ready, q_lookup_req, q_rsp_valid, q_rsp_hit, q_fill_req, q_inval_req;
    logic [1:0]  q_lookup_index, q_fill_index, q_inval_index;
    logic [13:0] q_lookup_tag, q_fill_tag;
    logic [1:0]  q_rsp_way, q_rsp_victim, q_fill_way, q_inval_way;
`ifdef TAG_PARITY_EN
    logic        rsp_perr, q_rsp_perr;
`endif

    always #5 clock = ~clock;

    cache_tag_store_nway dut (
        .clock(clock), .reset_n(reset_n), .ready(ready),
        .lookup_req(lookup_req), .lookup_index(lookup_index), .lookup_tag(lookup_tag),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_victim(rsp_victim),
`ifdef TAG_PARITY_EN
        .rsp_perr(rsp_perr),
`endif
        .fill_req(fill_req), .fill_index(fill_index), .fill_way(fill_way), .fill_tag(fill_tag),
        .inval_req(inval_req), .inval_index(inval_index), .inval_way(inval_way)
    );

    cache_tag_store_nway #(.AWIDTH(2), .TWIDTH(14), .WAYS(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .ready(q_ready),
        .lookup_req(q_lookup_req), .lookup_index(q_lookup_index), .lookup_tag(q_lookup_tag),
        .rsp_valid(q_rsp_valid), .rsp_hit(q_rsp_hit), .rsp_way(q_rsp_way),
        .rsp_victim(q_rsp_victim),
`ifdef TAG_PARITY_EN
        .rsp_perr(q_rsp_perr),
`endif
        .fill_req(q_fill_req), .fill_index(q_fill_index), .fill_way(q_fill_way),
        .fill_tag(q_fill_tag),
        .inval_req(q_inval_req), .inval_index(q_inval_index), .inval_way(q_inval_way)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: with two ways tree-PLRU is true LRU, so track the last-touched way per set.
    logic [13:0] m_tag   [8][2];
    bit          m_valid [8][2];
    int          m_last  [8];
    int          m_flush;
    bit          m_ready, e_valid, e_hit;
    int          e_way, e_victim;

    always @(posedge clock) begin
        if (!reset_n) begin
            m_ready = 0; m_flush = 0;
            e_valid = 0; e_hit = 0; e_way = 0; e_victim = 0;
            for (int s = 0; s < 8; s++) begin
                m_valid[s][0] = 0; m_valid[s][1] = 0; m_last[s] = -1;
            end
        end else if (m_ready) begin
            e_valid = 0;
            if (inval_req) m_valid[inval_index][inval_way] = 0;
            if (fill_req) begin
                m_tag[fill_index][fill_way]   = fill_tag;
                m_valid[fill_index][fill_way] = 1;
                m_last[fill_index]            = int'(fill_way);
            end
            if (lookup_req) begin
                e_valid = 1; e_hit = 0; e_way = 0;
                for (int w = 0; w < 2; w++) begin
                    if (!e_hit && m_valid[lookup_index][w] && m_tag[lookup_index][w] == lookup_tag) begin
                        e_hit = 1; e_way = w;
                    end
                end
                if (!m_valid[lookup_index][0])      e_victim = 0;
                else if (!m_valid[lookup_index][1]) e_victim = 1;
                else                                e_victim = (m_last[lookup_index] == 0) ? 1 : 0;
                if (e_hit) m_last[lookup_index] = e_way;
            end
        end else begin
            e_valid = 0;
            m_flush++;
            if (m_flush == 8) m_ready = 1;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("ready", ready, m_ready);
            check("rsp_valid", rsp_valid, e_valid);
            check("rsp_hit", rsp_hit, e_hit);
            check("rsp_way", rsp_way, e_way);
            check("rsp_victim", rsp_victim, e_victim);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic lookup_chk(input string name, input int idx, input int tag,
                              input int hit, input int way, input int vic);
        lookup_index = 3'(idx); lookup_tag = 14'(tag); lookup_req = 1; tick(); lookup_req = 0;
        check({name, "_valid"}, rsp_valid, 1);
        check({name, "_hit"}, rsp_hit, hit);
        check({name, "_way"}, rsp_way, way);
        check({name, "_victim"}, rsp_victim, vic);
    endtask

    task automatic fill(input int idx, input int way, input int tag);
        fill_index = 3'(idx); fill_way = 1'(way); fill_tag = 14'(tag); fill_req = 1; tick();
        fill_req = 0;
    endtask

    task automatic q_lookup_chk(input string name, input int idx, input int tag,
                                input int hit, input int way, input int vic);
        q_lookup_index = 2'(idx); q_lookup_tag = 14'(tag); q_lookup_req = 1; tick();
        q_lookup_req = 0;
        check({name, "_valid"}, q_rsp_valid, 1);
        check({name, "_hit"}, q_rsp_hit, hit);
        check({name, "_way"}, q_rsp_way, way);
        check({name, "_victim"}, q_rsp_victim, vic);
    endtask

    task automatic flush_chk(input string name);
        int n;
        bit seen;
        n = 0; seen = 0;
        tick();
        check({name, "_rst_ready"}, ready, 0);
        check({name, "_rst_valid"}, rsp_valid, 0);
        lookup_req = 1; lookup_index = 3'd3; lookup_tag = 14'h1A5;
        reset_n = 1;
        while (!ready && n < 20) begin
            tick();
            n++;
            seen |= rsp_valid;
        end
        lookup_req = 0;
        check({name, "_cycles"}, n, 8);
        tick();
        check({name, "_no_rsp"}, seen | rsp_valid, 0);
    endtask

    initial begin
        {lookup_req, fill_req, inval_req, q_lookup_req, q_fill_req, q_inval_req} = '0;
        {lookup_index, fill_index, inval_index, fill_way, inval_way} = '0;
        {lookup_tag, fill_tag, q_lookup_tag, q_fill_tag} = '0;
        {q_lookup_index, q_fill_index, q_inval_index, q_fill_way, q_inval_way} = '0;
        reset_n = 0;
        tick();
        chk_en = 1;
        check("rst_hit", rsp_hit, 0);
        check("rst_way", rsp_way, 0);
        check("rst_victim", rsp_victim, 0);
        reset_n = 0;
        flush_chk("flush1");
        check("q_ready", q_ready, 1);

        lookup_chk("t2_miss", 3, 'h1A5, 0, 0, 0);
        fill(3, 0, 'h1A5);
        lookup_chk("t2_hit", 3, 'h1A5, 1, 0, 1);

        fill(5, 0, 'h10);
        fill(5, 1, 'h20);
        lookup_chk("t3_hit0", 5, 'h10, 1, 0, 0);
        lookup_chk("t3_miss", 5, 'h30, 0, 0, 1);
        lookup_chk("t3_hit1", 5, 'h20, 1, 1, 1);
        lookup_chk("t3_miss2", 5, 'h30, 0, 0, 0);

        // Fill lands in the response cycle: response still reflects old contents.
        lookup_index = 3'd6; lookup_tag = 14'h77; lookup_req = 1; tick(); lookup_req = 0;
        fill_index = 3'd6; fill_way = 1'b0; fill_tag = 14'h77; fill_req = 1;
        check("t5_valid", rsp_valid, 1);
        check("t5_hit", rsp_hit, 0);
        tick();
        fill_req = 0;
        check("t5_hold_hit", rsp_hit, 0);
        lookup_chk("t5_rep", 6, 'h77, 1, 0, 1);

        // 4-way PLRU and fill-over-invalidate
        for (int w = 0; w < 4; w++) begin
            q_fill_index = 2'd2; q_fill_way = 2'(w); q_fill_tag = 14'(32'h100 + w); q_fill_req = 1;
            tick();
        end
        q_fill_req = 0;
        q_inval_index = 2'd2; q_inval_way = 2'd2; q_inval_req = 1; tick(); q_inval_req = 0;
        q_lookup_chk("t4_miss", 2, 'h3FF, 0, 0, 2);
        q_fill_index = 2'd2; q_fill_way = 2'd2; q_fill_tag = 14'h222; q_fill_req = 1;
        q_inval_index = 2'd2; q_inval_way = 2'd2; q_inval_req = 1;
        tick();
        q_fill_req = 0; q_inval_req = 0;
        q_lookup_chk("t4_fillwins", 2, 'h222, 1, 2, 0);
        q_lookup_chk("t4_hit0", 2, 'h100, 1, 0, 0);
        q_lookup_chk("t4_plru", 2, 'h3FF, 0, 0, 3);

        // Reset in the lookup's accept cycle drops the response and clears every set.
        fill(1, 0, 'h55);
        fill(1, 1, 'h66);
        lookup_index = 3'd1; lookup_tag = 14'h55; lookup_req = 1; reset_n = 0;
        flush_chk("flush2");
        lookup_chk("t6_gone1", 1, 'h55, 0, 0, 0);
        lookup_chk("t6_gone3", 3, 'h1A5, 0, 0, 0);
        lookup_chk("t6_gone5", 5, 'h20, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            reset_n      = ($urandom_range(0, 399) != 0);
            lookup_req   = $urandom_range(0, 1) == 1;
            lookup_index = 3'($urandom_range(0, 7));
            lookup_tag   = 14'($urandom_range(1, 4));
            fill_req     = $urandom_range(0, 2) == 0;
            fill_index   = 3'($urandom_range(0, 7));
            fill_way     = 1'($urandom_range(0, 1));
            fill_tag     = 14'($urandom_range(1, 4));
            inval_req    = $urandom_range(0, 3) == 0;
            inval_index  = $urandom_range(0, 1) == 0 ? fill_index : 3'($urandom_range(0, 7));
            inval_way    = 1'($urandom_range(0, 1));
            tick();
        end
        {lookup_req, fill_req, inval_req} = '0;
        reset_n = 1;
        repeat (12) tick();

`ifdef TAG_PARITY_EN
        chk_en = 0;
        fill(6, 0, 'h77);
        dut.par_q[6][0] = ~dut.par_q[6][0];
        lookup_index = 3'd6; lookup_tag = 14'h77; lookup_req = 1; tick(); lookup_req = 0;
        check("perr_hit", rsp_hit, 0);
        check("perr_flag", rsp_perr, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
